// File: rtl/conv_acc_calc.sv
// conv_acc_calc: KxK signed MAC with adder tree, CH-beat channel accumulation,
// bias, optional ReLU and output saturation behind a valid/ready handshake.
module conv_acc_calc #(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int E      = 4,
    parameter int CH     = 4,
    parameter int OUT_W  = 8,
    localparam int ACC_W = N + M + E + $clog2(CH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [KERNEL*KERNEL*N-1:0]      data2conv,
    input  logic [KERNEL*KERNEL*M-1:0]      w,
    input  logic                            en_in,
    output logic                            rdy_out,
    input  logic signed [ACC_W-1:0]         bias,
    input  logic                            relu_en,
    input  logic                            clr,
    output logic signed [OUT_W-1:0]         d_out,
    output logic                            en_out,
    input  logic                            rdy_in
);
    localparam int T  = KERNEL * KERNEL;
    localparam int P  = N + M;
    localparam int S  = N + M + E;
    localparam int CW = CH > 1 ? $clog2(CH) : 1;
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = -MAX_V - 1;

    logic                    stall, accept, last;
    logic                    v1, v2, v3;
    logic signed [P-1:0]     prod_c [T];
    logic signed [P-1:0]     prod1 [T];
    logic signed [S-1:0]     sum_c, sum2;
    logic signed [ACC_W-1:0] bias1, bias2, acc, acc_next;
    logic                    relu1, relu2;
    logic [CW-1:0]           cnt;
    logic signed [ACC_W:0]   biased, rect;
    logic signed [OUT_W-1:0] sat_c;

    assign stall   = en_out & ~rdy_in;
    assign rdy_out = ~stall;
    assign accept  = en_in & rdy_out & ~clr;
    assign last    = cnt == CW'(CH - 1);

    always_comb begin
        for (int i = 0; i < T; i++)
            prod_c[i] = P'($signed(data2conv[i*N +: N])) * P'($signed(w[i*M +: M]));
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < T; i++)
            sum_c = sum_c + S'(prod1[i]);
    end

    // v3 marks a partial group held in the accumulator, i.e. the count is nonzero
    always_comb begin
        acc_next = v3 ? acc + ACC_W'(sum2) : ACC_W'(sum2);
        biased   = (ACC_W+1)'(acc_next) + (ACC_W+1)'(bias2);
        rect     = (relu2 && biased[ACC_W]) ? '0 : biased;
        sat_c    = rect > MAX_V ? OUT_W'(MAX_V) : rect < MIN_V ? OUT_W'(MIN_V) : $signed(rect[OUT_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            d_out  <= '0;
            en_out <= 1'b0;
        end else if (clr) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            cnt    <= '0;
            en_out <= 1'b0;
        end else if (!stall) begin
            v1     <= accept;
            v2     <= v1;
            en_out <= v2 & last;
            if (v2) begin
                acc <= acc_next;
                v3  <= ~last;
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (v2 & last)
                d_out <= sat_c;
        end
    end

    // Datapath payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (accept) begin
            prod1 <= prod_c;
            bias1 <= bias;
            relu1 <= relu_en;
        end
        if (v1 & ~stall) begin
            sum2  <= sum_c;
            bias2 <= bias1;
            relu2 <= relu1;
        end
    end
endmodule
